// File: rtl/adpcm_voice_scheduler.sv
// adpcm_voice_scheduler: allocates ics_adpcm channels and sequences their register and global key-on/off writes
module adpcm_voice_scheduler #(
  parameter int CHANNELS = 4,
  parameter int CH_STRIDE = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                on_valid,
  output logic                on_ready,
  input  logic [15:0]         on_start,
  input  logic [15:0]         on_end,
  input  logic [15:0]         on_loop,
  input  logic                on_looped,
  input  logic [15:0]         on_volumes,
  input  logic [15:0]         on_pitch,
  input  logic [7:0]          on_tag,
  input  logic                off_valid,
  output logic                off_ready,
  input  logic [7:0]          off_tag,
  output logic [7:0]          ch_write_address,
  output logic [15:0]         ch_write_data,
  output logic                ch_write_en,
  output logic [1:0]          ch_write_byte_mask,
  input  logic                ch_write_ready,
  output logic                gb_write_address,
  output logic [CHANNELS-1:0] gb_write_data,
  output logic                gb_write_en,
  input  logic                gb_write_busy,
  input  logic                gb_write_ready,
  input  logic [CHANNELS-1:0] gb_playing,
  output logic [2:0]          alloc_channel,
  output logic                alloc_valid,
  output logic                stolen
);
  typedef enum logic [2:0] {IDLE, GB_STOP, CFG, CFG_GAP, GB_START, OFF_LOOKUP, GB_OFF} state_t;
  state_t state, state_n;
  logic [2:0] ch, reg_index, alloc_ch, oldest;
  logic [15:0] r_start, r_end, r_loop, r_volumes, r_pitch;
  logic [7:0] r_tag, r_off_tag, best;
  logic [7:0] ages [CHANNELS];
  logic [7:0] tags [CHANNELS];
  logic [CHANNELS-1:0] tag_valid, start_pending, free, hit, off_mask, onehot, start_mask, stop_mask;
  logic r_looped, steal, any_free, gb_en, gb_done, in_gb, on_acc, off_acc;
  assign off_acc = reset_n && state == IDLE && off_valid;
  assign on_acc = reset_n && state == IDLE && on_valid && !off_valid;
  assign on_ready = on_acc;
  assign off_ready = off_acc;
  assign free = ~gb_playing & ~start_pending;
  assign onehot = CHANNELS'(1) << ch;
  assign in_gb = state == GB_STOP || state == GB_START || state == GB_OFF;
  assign gb_done = gb_en && gb_write_ready;
  assign start_mask = (state == GB_START && gb_done) ? onehot : '0;
  assign stop_mask = (state == GB_OFF && gb_done) ? off_mask : '0;
  assign ch_write_en = state == CFG;
  assign ch_write_byte_mask = 2'b11;
  assign ch_write_address = 8'(32'(ch) * CH_STRIDE + 32'(reg_index));
  assign ch_write_data = reg_index == 3'd0 ? r_start :
                         reg_index == 3'd1 ? {15'd0, r_looped} :
                         reg_index == 3'd2 ? r_end :
                         reg_index == 3'd3 ? r_loop :
                         reg_index == 3'd4 ? r_volumes : r_pitch;
  assign gb_write_en = gb_en;
  assign gb_write_address = state != GB_START;
  assign gb_write_data = state == GB_OFF ? off_mask : onehot;
  always_comb begin
    alloc_ch = 3'd0;
    any_free = 1'b0;
    oldest = 3'd0;
    best = ages[0];
    hit = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (free[i]) begin
        alloc_ch = 3'(i);
        any_free = 1'b1;
      end
    end
    for (int i = 1; i < CHANNELS; i++) begin
      if (ages[i] > best) begin
        best = ages[i];
        oldest = 3'(i);
      end
    end
    if (!any_free) alloc_ch = oldest;
    for (int i = 0; i < CHANNELS; i++) hit[i] = tag_valid[i] && tags[i] == r_off_tag;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = off_acc ? OFF_LOOKUP : on_acc ? (any_free ? CFG : GB_STOP) : IDLE;
      GB_STOP:    state_n = gb_done ? CFG : GB_STOP;
      CFG:        state_n = ch_write_ready ? CFG_GAP : CFG;
      CFG_GAP:    state_n = reg_index == 3'd5 ? GB_START : CFG;
      GB_START:   state_n = gb_done ? IDLE : GB_START;
      OFF_LOOKUP: state_n = |hit ? GB_OFF : IDLE;
      GB_OFF:     state_n = gb_done ? IDLE : GB_OFF;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= !reset_n ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ch <= '0;
      reg_index <= '0;
      steal <= 1'b0;
      gb_en <= 1'b0;
      alloc_channel <= '0;
      alloc_valid <= 1'b0;
      stolen <= 1'b0;
      tag_valid <= '0;
      start_pending <= '0;
      off_mask <= '0;
      r_off_tag <= '0;
      r_tag <= '0;
      {r_start, r_end, r_loop, r_volumes, r_pitch, r_looped} <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        ages[i] <= '0;
        tags[i] <= '0;
      end
    end else begin
      alloc_valid <= state == GB_START && gb_done;
      stolen <= state == GB_START && gb_done && steal;
      gb_en <= gb_done ? 1'b0 : gb_en || (in_gb && !gb_write_busy);
      tag_valid <= (tag_valid & ~stop_mask) | start_mask;
      start_pending <= (start_pending & ~gb_playing & ~stop_mask) | start_mask;
      if (on_acc) begin
        ch <= alloc_ch;
        steal <= !any_free;
        reg_index <= '0;
        {r_start, r_end, r_loop, r_volumes, r_pitch, r_looped} <= {on_start, on_end, on_loop, on_volumes, on_pitch, on_looped};
        r_tag <= on_tag;
      end
      if (off_acc) r_off_tag <= off_tag;
      if (state == OFF_LOOKUP) off_mask <= hit;
      if (state == CFG_GAP) reg_index <= reg_index + 3'd1;
      if (state == GB_START && gb_done) begin
        alloc_channel <= ch;
        for (int i = 0; i < CHANNELS; i++) begin
          ages[i] <= 3'(i) == ch ? 8'd0 : ages[i] + {7'd0, ages[i] != 8'hff};
          if (3'(i) == ch) tags[i] <= r_tag;
        end
      end
    end
  end
endmodule
